gpu_cmd_defer_queue: RTL
========================

# gpu_cmd_defer_queue

Parametrised command scheduler between the GPU command bus receiver and the palette/header/RAM write ports. It enforces the GPU render contract: during a frame render, read commands pass straight through and write commands are held in a deferred FIFO. After the render ends, all deferred writes are issued in order before any new command is accepted. It asserts a hold flag so the controller cannot start the next frame until the drain completes.

## Interface
Parameters:
- ADDR_W, 16, command address width (layer/slot/index packed)
- DATA_W, 16, command data width
- DEPTH, 16, deferred-write FIFO depth; power of 2, ≥2
- CNT_W, $clog2(DEPTH+1), width of count output

Ports:
- clk_in  input  1  single clock; all logic on rising edge
- rst_in  input  1  reset, synchronous and active-high
- render_active_in  input  1  high for the duration of a frame render
- in_valid  input  1  upstream command valid
- in_ready  output  1  command accepted when in_valid & in_ready
- in_is_write  input  1  1 = write, 0 = read
- in_addr  input  ADDR_W  command address
- in_data  input  DATA_W  write data; ignored for reads
- out_valid  output  1  downstream command valid
- out_ready  input  1  downstream accepts when out_valid & out_ready
- out_is_write / out_addr / out_data  output  1 / ADDR_W / DATA_W  registered command
- render_hold_out  output  1  next render must not start
- defer_count_out  output  CNT_W  deferred writes currently queued
- protocol_err_out  output  1  sticky; render started while draining

## Operation
- slot_free = !out_valid | out_ready. The output register is a single entry.
- States: IDLE (pass-through), RENDER (defer writes), DRAIN (issue deferred writes).
- IDLE: in_ready = slot_free. An accepted command of either type loads the output register.
- RENDER:
  - A read is accepted when slot_free and loads the output register.
  - A write is accepted when the FIFO is not full and is pushed to the FIFO.
  - A blocked write stalls everything behind it, because the input is strictly in-order.
  - Reads therefore overtake earlier deferred writes. This is intended: a read returns the pre-render value.
- DRAIN: in_ready = 0. When slot_free and the FIFO is not empty, pop the FIFO into the output register.
- Transitions:
  - IDLE→RENDER when render_active_in = 1.
  - RENDER→DRAIN when render_active_in = 0 and count > 0.
  - RENDER→IDLE when render_active_in = 0 and count = 0.
  - DRAIN→IDLE when the FIFO is empty and the last drained write has handed off (out_valid = 0, or out_ready is high that cycle).
- Classification uses the registered state. A command accepted in the same cycle render_active_in changes is treated per the current state.
- render_active_in asserted while in DRAIN:
  - Set protocol_err_out; it clears only on rst_in.
  - Keep draining; no inputs are accepted.
  - Go DRAIN→RENDER (instead of IDLE) once the drain completes.
- render_hold_out = (state == DRAIN).
- defer_count_out is incremented on push and decremented on pop. A push and pop in the same cycle leaves it unchanged.
- rst_in mid-operation discards the FIFO contents and the output register. No deferred write is issued after reset.
- Reset values: state IDLE, out_valid 0, out_is_write/addr/data 0, render_hold_out 0, defer_count_out 0, protocol_err_out 0. in_ready during reset is 0.

## Timing
- Accept at cycle N → out_valid at N+1 (pass-through latency 1).
- FIFO pop at cycle N → out_valid at N+1. Back-to-back pops run at 1 per cycle when out_ready is held high.
- A push at N is visible to a pop at N+1 at the earliest. No same-cycle push-to-pop bypass.
- The state change takes effect the cycle after render_active_in is sampled.
- render_hold_out rises the cycle after render_active_in falls with count > 0.
- render_hold_out falls the cycle after the last deferred write's handshake.
- out_* are held stable while out_valid & !out_ready.

## Structure
- Shared package sparkbox_gpu_pkg holds:
  - state encodings (IDLE = 0, RENDER = 1, DRAIN = 2)
  - command field widths and the read/write opcode constant, shared with commandControlTop.
- One sub-module, gpu_sync_fifo: parametrised width (ADDR_W+DATA_W) and DEPTH, with full, empty and count outputs, synchronous reset.
- Scheduler FSM and output register live in gpu_cmd_defer_queue itself.

## Test plan
- Pass-through: IDLE, read 0x0035 → out_valid next cycle with same addr; defer_count_out stays 0.
- Deferral:
  - Stimulus: render high; write (0x0035, 0x7BEF), then read 0x0035.
  - Required: the read appears first. After render falls, the write appears; render_hold_out is high 1 cycle after the fall and low 1 cycle after the write's handshake.
- Full:
  - Stimulus: DEPTH=4, render high, 5 writes.
  - Required: in_ready drops after the 4th write and defer_count_out = 4. A read queued behind the 5th write is not issued until the drain.
- Backpressure:
  - Stimulus: out_ready low 3 cycles during DRAIN.
  - Required: out_* hold stable and all writes emerge in FIFO order with no loss or duplication.
- Protocol error:
  - Stimulus: render re-asserted during DRAIN with 2 writes queued.
  - Required: protocol_err_out = 1, both writes still issued, then state RENDER.
- Reset mid-drain: rst_in with 3 writes queued → all outputs at reset values next cycle and no write issued afterwards.

Source files
------------

// File: rtl/sparkbox_gpu_pkg.sv
// Types and constants shared by the GPU command path (scheduler and commandControlTop).
// Holds no logic.
// Nothing here applies backpressure.
package sparkbox_gpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RENDER = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    localparam int CMD_ADDR_W = 16;
    localparam int CMD_DATA_W = 16;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/gpu_sync_fifo.sv
// Synchronous show-ahead FIFO holding deferred commands.
// Latency: a push at N is readable at N+1. There is no push-to-pop bypass.
// Backpressure: a push while full and a pop while empty are ignored. The caller gates on full/empty.
module gpu_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push_vld && !full;
    assign do_pop  = pop_vld && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap without an explicit compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gpu_cmd_defer_queue.sv
// Passes reads through and defers writes issued during a frame render, then drains the deferred writes in order.
// Latency: 1 cycle from input accept or FIFO pop to out_valid.
// Backpressure: out_* hold while out_ready is low. in_ready drops when the output slot or the FIFO is full, and during the drain.
module gpu_cmd_defer_queue
    import sparkbox_gpu_pkg::*;
#(
    parameter int ADDR_W = CMD_ADDR_W,
    parameter int DATA_W = CMD_DATA_W,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              render_active_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_write,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_is_write,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              render_hold_out,
    output logic [CNT_W-1:0]  defer_count_out,
    output logic              protocol_err_out
);

    localparam int CMD_W = ADDR_W + DATA_W;

    state_t             state;
    logic               slot_free;
    logic               accept;
    logic               push;
    logic               load_in;
    logic               pop;
    logic               drain_done;
    logic               rerender_pend;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CMD_W-1:0]   fifo_dat;
    logic [CNT_W-1:0]   fifo_count;

    always_comb begin
        slot_free = !out_valid || out_ready;
        in_ready  = 1'b0;
        if (!rst_in) begin
            case (state)
                ST_IDLE:   in_ready = slot_free;
                ST_RENDER: in_ready = (in_is_write == OP_WRITE) ? !fifo_full : slot_free;
                default:   in_ready = 1'b0;
            endcase
        end
    end

    assign accept     = in_valid && in_ready;
    assign push       = accept && (state == ST_RENDER) && (in_is_write == OP_WRITE);
    assign load_in    = accept && !push;
    assign pop        = (state == ST_DRAIN) && slot_free && !fifo_empty;
    assign drain_done = (state == ST_DRAIN) && fifo_empty && slot_free;

    gpu_sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_defer_fifo (
        .clk      (clk_in),
        .rst      (rst_in),
        .push_vld (push),
        .push_dat ({in_addr, in_data}),
        .pop_vld  (pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign render_hold_out = (state == ST_DRAIN);
    assign defer_count_out = fifo_count;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state            <= ST_IDLE;
            out_valid        <= 1'b0;
            out_is_write     <= 1'b0;
            out_addr         <= '0;
            out_data         <= '0;
            protocol_err_out <= 1'b0;
            rerender_pend    <= 1'b0;
        end else begin
            if (load_in) begin
                out_valid    <= 1'b1;
                out_is_write <= in_is_write;
                out_addr     <= in_addr;
                out_data     <= in_data;
            end else if (pop) begin
                out_valid              <= 1'b1;
                out_is_write           <= OP_WRITE;
                {out_addr, out_data}   <= fifo_dat;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (render_active_in) state <= ST_RENDER;
                end
                ST_RENDER: begin
                    // A write pushed on the falling cycle must still be drained.
                    if (!render_active_in) begin
                        state <= (fifo_count != '0 || push) ? ST_DRAIN : ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (render_active_in) begin
                        protocol_err_out <= 1'b1;
                        rerender_pend    <= 1'b1;
                    end
                    if (drain_done) begin
                        state         <= (render_active_in || rerender_pend) ? ST_RENDER : ST_IDLE;
                        rerender_pend <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
